// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, scheduler state type and the
// rotate / small-sigma helpers used by the message scheduler and round core.
package sha256_pkg;

   localparam int ROUNDS  = 64;
   localparam int WORD_W  = 32;
   localparam int ROUND_W = 6;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } sched_state_t;

   localparam logic [WORD_W-1:0] K [0:ROUNDS-1] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [WORD_W-1:0] H0 [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Rotate right; n is always a small constant in [1, WORD_W-1].
   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_msg_scheduler.sv
// sha256_msg_scheduler: expands one padded 512-bit block into W0..W63 and
// streams one word per beat to the round core.
// Optional macro SHA256_SCHED_KT_EN adds kt_o = K[round_o] from the package.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. blk_ready_o is high only in IDLE; wt_valid_o is high only in
// STREAM and, once high, stays high with wt_o/round_o/last_o stable until the
// beat fires. No output depends combinationally on blk_valid_i or wt_ready_i.
module sha256_msg_scheduler
   import sha256_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               blk_valid_i,
   output logic               blk_ready_o,
   input  logic [511:0]       blk_i,
   output logic               wt_valid_o,
   input  logic               wt_ready_i,
   output logic [WORD_W-1:0]  wt_o,
   output logic [ROUND_W-1:0] round_o,
   output logic               last_o,
   output logic               busy_o
`ifdef SHA256_SCHED_KT_EN
   ,
   output logic [WORD_W-1:0]  kt_o
`endif
);

   sched_state_t        state_q, state_d;
   logic [WORD_W-1:0]   w_q [16];
   logic [ROUND_W-1:0]  t_q;
   logic                accept;
   logic                beat;
   logic                at_last;
   logic [WORD_W-1:0]   w_new;

   assign accept  = (state_q == IDLE) && blk_valid_i;
   assign beat    = (state_q == STREAM) && wt_ready_i;
   assign at_last = (t_q == ROUND_W'(ROUNDS - 1));

   // Next window word; 32-bit adds wrap, carries dropped. Past t=47 this
   // produces words beyond W63 that are never presented.
   assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: accept a block in IDLE, return to IDLE after the round-63 beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = STREAM;
         STREAM:  if (beat && at_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: everything but blk_ready_o is forced to zero outside STREAM.
   always_comb begin
      blk_ready_o = 1'b0;
      wt_valid_o  = 1'b0;
      wt_o        = '0;
      round_o     = '0;
      last_o      = 1'b0;
      busy_o      = 1'b0;
`ifdef SHA256_SCHED_KT_EN
      kt_o        = '0;
`endif
      case (state_q)
         IDLE: blk_ready_o = 1'b1;
         STREAM: begin
            wt_valid_o = 1'b1;
            wt_o       = w_q[0];
            round_o    = t_q;
            last_o     = at_last;
            busy_o     = 1'b1;
`ifdef SHA256_SCHED_KT_EN
            kt_o       = K[t_q];
`endif
         end
         default: blk_ready_o = 1'b0;
      endcase
   end

   // 16-word window: load M0..M15 on accept, shift and append on each beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < 16; i++) w_q[i] <= blk_i[511 - 32*i -: 32];
      end else if (beat) begin
         for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
         w_q[15] <= w_new;
      end
   end

   // Round counter; leaving STREAM at 63 keeps it from ever wrapping while valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         t_q <= '0;
      else if (accept) t_q <= '0;
      else if (beat)   t_q <= t_q + 1'b1;
   end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// tb_sha256_msg_scheduler: scoreboard bench for the SHA-256 message scheduler.
module tb_sha256_msg_scheduler;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic         blk_valid_i;
   logic         blk_ready_o;
   logic [511:0] blk_i;
   logic         wt_valid_o;
   logic         wt_ready_i;
   logic [31:0]  wt_o;
   logic [5:0]   round_o;
   logic         last_o;
   logic         busy_o;
`ifdef SHA256_SCHED_KT_EN
   logic [31:0]  kt_o;
`endif

   always #5 clk = ~clk;

   sha256_msg_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .blk_valid_i (blk_valid_i),
      .blk_ready_o (blk_ready_o),
      .blk_i       (blk_i),
      .wt_valid_o  (wt_valid_o),
      .wt_ready_i  (wt_ready_i),
      .wt_o        (wt_o),
      .round_o     (round_o),
      .last_o      (last_o),
      .busy_o      (busy_o)
`ifdef SHA256_SCHED_KT_EN
      ,
      .kt_o        (kt_o)
`endif
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];
   logic [5:0]  rnd_q [$];
   logic [31:0] ref_w [64];
   logic [31:0] obs_w [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction

   function automatic logic [31:0] ref_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   task automatic gen_ref(input logic [511:0] b);
      for (int t = 0; t < 16; t++) ref_w[t] = b[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         ref_w[t] = ref_s1(ref_w[t-2]) + ref_w[t-7] + ref_s0(ref_w[t-15]) + ref_w[t-16];
   endtask

   task automatic push_block(input logic [511:0] b);
      gen_ref(b);
      for (int t = 0; t < 64; t++) begin
         exp_q.push_back(ref_w[t]);
         rnd_q.push_back(6'(t));
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst && wt_valid_o) begin
         check("blk_ready_in_stream", 32'(blk_ready_o), 32'd0);
         check("busy_in_stream", 32'(busy_o), 32'd1);
         check("stream_has_expectation", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check("wt", wt_o, exp_q[0]);
            check("round", 32'(round_o), 32'(rnd_q[0]));
            check("last", 32'(last_o), 32'(rnd_q[0] == 6'd63));
`ifdef SHA256_SCHED_KT_EN
            if (rnd_q[0] == 6'd0)  check("kt_r0", kt_o, 32'h428a2f98);
            if (rnd_q[0] == 6'd1)  check("kt_r1", kt_o, 32'h71374491);
            if (rnd_q[0] == 6'd63) check("kt_r63", kt_o, 32'hc67178f2);
`endif
            if (wt_ready_i) begin
               obs_w[rnd_q[0]] = wt_o;
               void'(exp_q.pop_front());
               void'(rnd_q.pop_front());
            end
         end
      end else if (!rst) begin
         check("idle_wt", wt_o, 32'd0);
         check("idle_round", 32'(round_o), 32'd0);
         check("idle_last", 32'(last_o), 32'd0);
         check("idle_busy", 32'(busy_o), 32'd0);
`ifdef SHA256_SCHED_KT_EN
         check("idle_kt", kt_o, 32'd0);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic offer_block(input logic [511:0] b, input bit keep_valid);
      int c;
      @(posedge clk); #1;
      blk_i       = b;
      blk_valid_i = 1'b1;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!blk_ready_o && c < 300);
      check("accept_ready", 32'(blk_ready_o), 32'd1);
      push_block(b);
      @(posedge clk); #1;
      if (!keep_valid) blk_valid_i = 1'b0;
   endtask

   // mode 0: ready high; mode 1: 3-cycle stall at round 20 then random; mode 2: random
   task automatic drain(input int mode);
      int cycles;
      int stall;
      cycles = 0;
      stall  = 0;
      while (exp_q.size() != 0 && cycles < 3000) begin
         case (mode)
            0: wt_ready_i = 1'b1;
            1: begin
               if (stall < 3 && wt_valid_o && round_o == 6'd20) begin
                  wt_ready_i = 1'b0;
                  stall++;
               end else if (stall >= 3) wt_ready_i = 1'($urandom_range(0, 1));
               else wt_ready_i = 1'b1;
            end
            default: wt_ready_i = 1'($urandom_range(0, 1));
         endcase
         @(posedge clk); #1;
         cycles++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      if (mode == 0) check("beats_per_block", 32'(cycles), 32'd64);
      if (mode == 1) check("stall_applied", 32'(stall), 32'd3);
      exp_q.delete();
      rnd_q.delete();
      wt_ready_i = 1'b1;
      @(negedge clk);
      check("ready_after_last", 32'(blk_ready_o), 32'd1);
      check("valid_after_last", 32'(wt_valid_o), 32'd0);
   endtask

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
      return b;
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      logic [511:0] abc;
      logic [511:0] blk_b;
      int c;
      abc = {32'h61626380, 448'b0, 32'h00000018};

      rst         = 1'b1;
      blk_valid_i = 1'b0;
      wt_ready_i  = 1'b1;
      blk_i       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(wt_valid_o), 32'd0);
      check("rst_wt", wt_o, 32'd0);
      check("rst_round", 32'(round_o), 32'd0);
      check("rst_last", 32'(last_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_blk_ready", 32'(blk_ready_o), 32'd1);

      // "abc" block at full rate
      offer_block(abc, 1'b0);
      drain(0);
      check("abc_w0", obs_w[0], 32'h61626380);
      check("abc_w15", obs_w[15], 32'h00000018);
      check("abc_w16", obs_w[16], 32'h61626380);
      check("abc_w17", obs_w[17], 32'h000f0000);
      check("abc_w63", obs_w[63], ref_w[63]);

      // backpressure
      offer_block(abc, 1'b0);
      drain(1);

      // block offered during STREAM; second block queued behind the first
      blk_b = rand_block();
      offer_block(abc, 1'b1);
      blk_i = blk_b;
      push_block(blk_b);
      c = 0;
      while (exp_q.size() > 64 && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      check("overlap_first_done", 32'(exp_q.size()), 32'd64);
      @(negedge clk);
      check("overlap_ready", 32'(blk_ready_o), 32'd1);
      @(posedge clk); #1;
      blk_valid_i = 1'b0;
      check("overlap_w0_valid", 32'(wt_valid_o), 32'd1);
      check("overlap_w0", wt_o, blk_b[511:480]);
      drain(0);

      // reset mid-block
      offer_block(abc, 1'b0);
      c = 0;
      while (round_o != 6'd30 && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      check("reached_round30", 32'(round_o), 32'd30);
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(wt_valid_o), 32'd0);
      check("midrst_wt", wt_o, 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_round", 32'(round_o), 32'd0);
      exp_q.delete();
      rnd_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_blk_ready", 32'(blk_ready_o), 32'd1);
      offer_block(abc, 1'b0);
      drain(0);

      // all-ones block
      offer_block({512{1'b1}}, 1'b0);
      drain(0);

      // random blocks, alternating full-rate and random ready
      for (int n = 0; n < 100; n++) begin
         offer_block(rand_block(), 1'b0);
         drain((n % 2 == 0) ? 2 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
